dds_signal_generator: RTL and testbench

Direct digital synthesis (DDS) waveform generator producing an 8-bit unsigned sample stream from a 32-bit phase accumulator. It sits between the system clock domain and an external 8-bit DAC. A 4-bit one-hot select chooses sine, square, triangle or sawtooth. Output frequency is fixed by parameter, about 500 Hz at a 50 MHz clock.

---
 rtl/dds_signal_generator.sv | 74 +++++++
 tb/tb_dds_signal_generator.sv | 133 +++++++++++++
 2 files changed

// File: rtl/dds_signal_generator.sv
// DDS waveform generator: 32-bit phase accumulator driving an 8-bit sample stream.
// Sine, square, triangle or sawtooth are chosen by a one-hot select; other codes output zero.
module dds_signal_generator #(
    parameter logic [31:0] FREQ_CTRL  = 32'd42949,
    parameter logic [11:0] PHASE_CTRL = 12'd1024
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] wave_select,
    output logic [7:0] data_out
);

    logic [31:0] acc;
    logic [11:0] addr;
    logic [11:0] tri_addr;
    logic [7:0]  s;
    logic [5:0]  q;
    logic [6:0]  q_mag;
    logic [7:0]  sample_next;

    // Quarter-wave table: round(127*sin(2*pi*j/256)) for j = 0..64.
    function automatic logic [6:0] quarter_sine(input logic [6:0] j);
        logic [6:0] v;
        case (j)
            7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
            7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
            7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
            7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
            7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
            7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
            7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
            7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
            7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
            7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
            7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
            7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
            7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
            7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
            7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
            7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
            default: v = 7'd127;
        endcase
        return v;
    endfunction

    always_comb begin
        sample_next = 8'd0;
        s           = 8'(addr >> 4);
        q           = s[5:0];
        // Odd quadrants read the table mirrored; the upper half is the negated lobe.
        q_mag       = quarter_sine(s[6] ? (7'd64 - {1'b0, q}) : {1'b0, q});
        tri_addr    = addr[11] ? ~addr : addr;
        case (wave_select)
            4'b0001: sample_next = s[7] ? (8'd128 - {1'b0, q_mag}) : (8'd128 + {1'b0, q_mag});
            4'b0010: sample_next = addr[11] ? 8'd0 : 8'd255;
            4'b0100: sample_next = 8'(tri_addr >> 3);
            4'b1000: sample_next = s;
            default: sample_next = 8'd0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            acc      <= 32'd0;
            addr     <= 12'd0;
            data_out <= 8'd0;
        end else begin
            acc      <= acc + FREQ_CTRL;
            addr     <= acc[31:20] + PHASE_CTRL;
            data_out <= sample_next;
        end
    end

endmodule

// File: tb/tb_dds_signal_generator.sv
// Scoreboard bench for dds_signal_generator: expected samples are derived from the
// elapsed edge count since reset release and pushed to a queue checked by a monitor.
module tb_dds_signal_generator;

    localparam longint FREQ  = 42949;
    localparam longint PHASE = 1024;
    localparam real    PI    = 3.14159265358979;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [3:0] wave_select;
    logic [7:0] data_out;

    int     exp_q[$];
    int     n_cmp;
    int     n_err;
    longint m;
    longint cyc;

    dds_signal_generator #(.FREQ_CTRL(32'd42949), .PHASE_CTRL(12'd1024)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .wave_select(wave_select),
        .data_out   (data_out)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Table address held in the address register after edge k-1 of the run.
    function automatic longint addr_at(input longint k);
        longint phase;
        if (k <= 1) return 0;
        phase = ((k - 2) * FREQ) % 64'h1_0000_0000;
        return ((phase >> 20) + PHASE) % 4096;
    endfunction

    function automatic int wave(input longint a, input logic [3:0] sel);
        int s;
        s = int'(a / 16);
        case (sel)
            4'b0001: return 128 + int'(127.0 * $sin(2.0 * PI * real'(s) / 256.0));
            4'b0010: return (a < 2048) ? 255 : 0;
            4'b0100: return (a < 2048) ? int'(a / 8) : 255 - int'((a - 2048) / 8);
            4'b1000: return s;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input logic rst_n, input logic [3:0] sel);
        @(negedge sys_clk);
        sys_rst_n   = rst_n;
        wave_select = sel;
        if (!rst_n) begin
            m = 0;
            exp_q.push_back(0);
        end else begin
            m = m + 1;
            exp_q.push_back(wave(addr_at(m), sel));
        end
    endtask

    function automatic logic [3:0] pick_sel();
        case ($urandom_range(0, 7))
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            3: return 4'b1000;
            4: return 4'b0000;
            5: return 4'b0011;
            6: return 4'b1111;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    // Monitor: one sample per clock, compared against the head of the queue.
    initial begin
        int e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (data_out !== 8'(e)) begin
                    n_err++;
                    if (n_err <= 20)
                        $display("FAIL data_out at cycle %0d: got %0d expected %0d", cyc, data_out, e);
                end
            end
            cyc++;
        end
    end

    initial begin
        logic [3:0] sel;
        n_cmp = 0;
        n_err = 0;
        m = 0;
        cyc = 0;
        sys_rst_n = 1'b0;
        wave_select = 4'b0001;

        repeat (10) drive(1'b0, 4'b0001);
        repeat (4) drive(1'b1, 4'b0001);

        sel = 4'b0010;
        for (int i = 0; i < 86000; i++) begin
            if ($urandom_range(0, 399) == 0) sel = pick_sel();
            drive(1'b1, sel);
        end

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(1, 3)) drive(1'b0, pick_sel());
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 19) == 0) sel = pick_sel();
                drive(1'b1, sel);
            end
        end

        repeat (3) @(posedge sys_clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d samples unchecked, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
